mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the registered 4:1 data mux and drives its 2-bit select.
- Four requesters compete for the shared mux path; the arbiter grants one at a time and holds the grant until the owner releases it or a hold-timeout expires.
- It also provides a valid flag delayed by one cycle, which lines up with the mux's registered output.

---
 rtl/mux4_rr_arbiter.sv | 105 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a registered 4:1 mux.
// Optional ARB_LOCK_EN adds a lock input that defers the hold-timeout.
module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  localparam logic [CNT_W-1:0] HoldLim = CNT_W'(HOLD_MAX);

  state_e           state;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;
  logic             lock_hold;

`ifdef ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // sel doubles as the owner index while in StOwn.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= StIdle;
      gnt       <= 4'b0000;
      sel       <= 2'b00;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= 2'b00;
      cnt       <= '0;
    end else begin
      out_valid <= busy;
      timeout   <= 1'b0;
      case (state)
        StIdle: begin
          if (found) begin
            state <= StOwn;
            gnt   <= 4'b0001 << pick;
            sel   <= pick;
            busy  <= 1'b1;
            cnt   <= CNT_W'(1);
          end
        end
        StOwn: begin
          if (done || !req[sel]) begin
            state <= StIdle;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            ptr   <= sel + 2'd1;
            cnt   <= '0;
          end else if (cnt == HoldLim && !lock_hold) begin
            state   <= StIdle;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            ptr     <= sel + 2'd1;
            cnt     <= '0;
            timeout <= 1'b1;
          end else if (cnt != HoldLim) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= StIdle;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed vector table plus
// randomized traffic against a behavioural model (HOLD_MAX=4).
module tb_mux4_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       out_valid;
  logic       timeout;

  mux4_rr_arbiter #(
    .HOLD_MAX(HOLD),
    .CNT_W   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .sel      (sel),
    .busy     (busy),
    .out_valid(out_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] q;
    logic       d;
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       o;
    logic       t;
  } vec_t;

  vec_t tbl[$];

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: owner index (-1 when idle), hold length, rotation pointer.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  int m_sel   = 0;
  int m_ov    = 0;
  int m_to    = 0;

  task automatic add(input logic r, input logic [3:0] q, input logic d, input logic [3:0] g,
                     input logic [1:0] s, input logic b, input logic o, input logic t);
    vec_t v;
    v.r = r; v.q = q; v.d = d; v.g = g; v.s = s; v.b = b; v.o = o; v.t = t;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] q, input logic d);
    if (!r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_sel = 0; m_ov = 0; m_to = 0;
    end else begin
      m_ov = (m_owner >= 0) ? 1 : 0;
      m_to = 0;
      if (m_owner < 0) begin
        for (int i = 0; i < 4; i++) begin
          int j;
          j = (m_ptr + i) % 4;
          if (m_owner < 0 && q[j]) begin
            m_owner = j; m_sel = j; m_held = 1;
          end
        end
      end else if (d || !q[m_owner]) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1;
      end else if (m_held == HOLD) begin
        m_ptr = (m_owner + 1) % 4; m_owner = -1; m_to = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] q, input logic d);
    logic [3:0] eg;
    rst = r; req = q; done = d;
    @(posedge clk);
    model_edge(r, q, d);
    #1;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("model_gnt", gnt, eg);
    chk("model_sel", {2'b00, sel}, 4'(m_sel));
    chk("model_busy", {3'b000, busy}, 4'(m_owner >= 0));
    chk("model_out_valid", {3'b000, out_valid}, 4'(m_ov));
    chk("model_timeout", {3'b000, timeout}, 4'(m_to));
    chk("onehot_gnt", {3'b000, $onehot0(gnt)}, 4'b0001);
  endtask

  initial begin
    rst = 1'b0; req = 4'b0000; done = 1'b0;

    //  r  req     d  gnt     sel b  ov to
    // Reset held with all requests, then first grant.
    add(0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 4'hF, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'hF, 0, 4'b0001, 0, 1, 0, 0);
    // Rotation 0,1,2,3,0 with done on the 2nd grant cycle.
    add(1, 4'hF, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'hF, 1, 4'b0000, 0, 0, 1, 0);
    add(1, 4'hF, 0, 4'b0010, 1, 1, 0, 0);
    add(1, 4'hF, 0, 4'b0010, 1, 1, 1, 0);
    add(1, 4'hF, 1, 4'b0000, 1, 0, 1, 0);
    add(1, 4'hF, 0, 4'b0100, 2, 1, 0, 0);
    add(1, 4'hF, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'hF, 1, 4'b0000, 2, 0, 1, 0);
    add(1, 4'hF, 0, 4'b1000, 3, 1, 0, 0);
    add(1, 4'hF, 0, 4'b1000, 3, 1, 1, 0);
    add(1, 4'hF, 1, 4'b0000, 3, 0, 1, 0);
    add(1, 4'hF, 0, 4'b0001, 0, 1, 0, 0);
    add(1, 4'hF, 0, 4'b0001, 0, 1, 1, 0);
    add(1, 4'hF, 1, 4'b0000, 0, 0, 1, 0);
    // Pointer skip: after source 1, only source 0 requests.
    add(1, 4'hF, 0, 4'b0010, 1, 1, 0, 0);
    add(1, 4'hF, 1, 4'b0000, 1, 0, 1, 0);
    add(1, 4'h1, 0, 4'b0001, 0, 1, 0, 0);
    add(1, 4'h0, 0, 4'b0000, 0, 0, 1, 0);
    // Timeout after 4 held cycles, then re-grant.
    add(1, 4'h4, 0, 4'b0100, 2, 1, 0, 0);
    add(1, 4'h4, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h4, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h4, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h4, 0, 4'b0000, 2, 0, 1, 1);
    add(1, 4'h4, 0, 4'b0100, 2, 1, 0, 0);
    // done in the 4th grant cycle: normal release, no timeout.
    add(1, 4'h4, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h4, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h4, 0, 4'b0100, 2, 1, 1, 0);
    add(1, 4'h4, 1, 4'b0000, 2, 0, 1, 0);
    // Reset mid-grant clears pointer.
    add(1, 4'h2, 0, 4'b0010, 1, 1, 0, 0);
    add(0, 4'h2, 0, 4'b0000, 0, 0, 0, 0);
    add(1, 4'hA, 0, 4'b0010, 1, 1, 0, 0);
    add(1, 4'h0, 0, 4'b0000, 1, 0, 1, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].q, tbl[i].d);
      chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
      chk($sformatf("tbl%0d_sel", i), {2'b00, sel}, {2'b00, tbl[i].s});
      chk($sformatf("tbl%0d_busy", i), {3'b000, busy}, {3'b000, tbl[i].b});
      chk($sformatf("tbl%0d_out_valid", i), {3'b000, out_valid}, {3'b000, tbl[i].o});
      chk($sformatf("tbl%0d_timeout", i), {3'b000, timeout}, {3'b000, tbl[i].t});
    end

    // Random traffic: sticky-ish requests, occasional done and reset.
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic [3:0] q;
      logic       d;
      r = ($urandom_range(0, 79) != 0);
      q = ($urandom_range(0, 3) == 0) ? 4'($urandom) : req;
      if ($urandom_range(0, 9) == 0) q = 4'b0000;
      d = ($urandom_range(0, 5) == 0);
      cyc(r, q, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
